// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd requester and the gcd core it drives.
//   gcd_req_state_e : requester FSM encoding
//   GCD_WIDTH       : operand/result width common to requester and core
package gcd_pkg;

    localparam int GCD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        OUT      = 2'd3
    } gcd_req_state_e;

endpackage

// File: rtl/gcd_req_timer.sv
// Response timer for the gcd requester. The count clears on clr and advances
// by one on each cycle with en. tc flags that the count has reached
// TIMEOUT_CYCLES-1.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous reset, active-low
//   clr    force count to 0 (has priority over en)
//   en     advance count by one
//   tc     terminal count reached
module gcd_req_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] count;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + TW'(1);
        end
    end

    assign tc = (count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gcd_requester.sv
// Initiator for the gcd start/busy/valid protocol. Takes operand pairs from a
// valid/ready stream, issues each to the gcd core with a one-cycle start and
// held operands, and returns the result (or a timeout marker) on a
// valid/ready result stream.
// Ports:
//   clk_i, rst_i                    clock; synchronous active-low reset
//   op_valid_i/op_ready_o           operand stream handshake
//   op_a_i, op_b_i                  operands
//   res_valid_o/res_ready_i         result stream handshake
//   res_data_o, res_timeout_o       result, timeout qualifier (data 0 on timeout)
//   gcd_start_o, gcd_a_o, gcd_b_o   to core
//   gcd_busy_i, gcd_valid_i,
//   gcd_result_i                    from core
//   done_count_o                    completed requests, saturating
// Build option: GCD_ZERO_BYPASS_EN answers pairs with a zero operand locally.
//
// state    | meaning
// IDLE     | ready for an operand pair
// ISSUE    | operands held, waiting for idle core to pulse start
// WAIT_RES | core running, timer counting
// OUT      | result presented until accepted
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH          = GCD_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  logic [WIDTH-1:0]     op_a_i,
    input  logic [WIDTH-1:0]     op_b_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [WIDTH-1:0]     res_data_o,
    output logic                 res_timeout_o,
    output logic                 gcd_start_o,
    output logic [WIDTH-1:0]     gcd_a_o,
    output logic [WIDTH-1:0]     gcd_b_o,
    input  logic                 gcd_busy_i,
    input  logic                 gcd_valid_i,
    input  logic [WIDTH-1:0]     gcd_result_i,
    output logic [CNT_WIDTH-1:0] done_count_o
);

    gcd_req_state_e state_q, state_d;
    logic timer_clr, timer_en, timer_tc;

`ifdef GCD_ZERO_BYPASS_EN
    logic zero_pair;
    assign zero_pair = (op_a_i == '0) || (op_b_i == '0);
`endif

    gcd_req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    // op_ready_o and gcd_start_o are gated by reset so an asserted reset
    // withdraws them in the same cycle.
    always_comb begin
        state_d     = state_q;
        op_ready_o  = 1'b0;
        gcd_start_o = 1'b0;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            IDLE: begin
                op_ready_o = rst_i;
                if (op_valid_i) begin
`ifdef GCD_ZERO_BYPASS_EN
                    state_d = zero_pair ? OUT : ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                // A valid still high from the previous request must drain
                // first, otherwise it would be mistaken for this answer.
                if (!gcd_busy_i && !gcd_valid_i) begin
                    gcd_start_o = rst_i;
                    timer_clr   = 1'b1;
                    state_d     = WAIT_RES;
                end
            end
            WAIT_RES: begin
                timer_en = 1'b1;
                if (gcd_valid_i || timer_tc) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            res_valid_o   <= 1'b0;
            res_data_o    <= '0;
            res_timeout_o <= 1'b0;
            gcd_a_o       <= '0;
            gcd_b_o       <= '0;
            done_count_o  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (op_valid_i) begin
`ifdef GCD_ZERO_BYPASS_EN
                        if (zero_pair) begin
                            res_data_o    <= op_a_i | op_b_i;
                            res_timeout_o <= 1'b0;
                            res_valid_o   <= 1'b1;
                        end else begin
                            gcd_a_o <= op_a_i;
                            gcd_b_o <= op_b_i;
                        end
`else
                        gcd_a_o <= op_a_i;
                        gcd_b_o <= op_b_i;
`endif
                    end
                end
                WAIT_RES: begin
                    // A valid arriving on the timeout cycle still counts.
                    if (gcd_valid_i) begin
                        res_data_o    <= gcd_result_i;
                        res_timeout_o <= 1'b0;
                        res_valid_o   <= 1'b1;
                    end else if (timer_tc) begin
                        res_data_o    <= '0;
                        res_timeout_o <= 1'b1;
                        res_valid_o   <= 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        if (done_count_o != {CNT_WIDTH{1'b1}}) begin
                            done_count_o <= done_count_o + CNT_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
module tb_gcd_requester;

    localparam int W        = 32;
    localparam int CORE_LAT = 3;
    localparam int VHOLD    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [W-1:0]  res_data;
    logic          res_timeout;
    logic          gcd_start;
    logic [W-1:0]  gcd_a, gcd_b;
    logic          core_busy = 1'b0;
    logic          core_valid = 1'b0;
    logic [W-1:0]  core_res = '0;
    logic [15:0]   done_count;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int core_cnt = 0;
    int vcnt = 0;
    bit core_dead = 1'b0;

    always #5 clk = ~clk;

    gcd_requester #(.WIDTH(W), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .op_valid_i    (op_valid),
        .op_ready_o    (op_ready),
        .op_a_i        (op_a),
        .op_b_i        (op_b),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_data_o    (res_data),
        .res_timeout_o (res_timeout),
        .gcd_start_o   (gcd_start),
        .gcd_a_o       (gcd_a),
        .gcd_b_o       (gcd_b),
        .gcd_busy_i    (core_busy),
        .gcd_valid_i   (core_valid),
        .gcd_result_i  (core_res),
        .done_count_o  (done_count)
    );

    function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural core: busy for CORE_LAT+1 cycles, then valid held VHOLD+1 cycles.
    always @(posedge clk) begin
        if (gcd_start) begin
            start_cnt++;
            chk("start_core_idle", {31'd0, core_busy | core_valid}, 32'd0);
        end
        if (gcd_start && !core_busy && !core_valid) begin
            if (!core_dead) begin
                core_busy <= 1'b1;
                core_cnt  <= CORE_LAT;
                core_res  <= gcd_fn(gcd_a, gcd_b);
            end
        end else if (core_busy) begin
            if (core_cnt == 0) begin
                core_busy  <= 1'b0;
                core_valid <= 1'b1;
                vcnt       <= VHOLD;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end else if (core_valid) begin
            if (vcnt == 0) core_valid <= 1'b0;
            else vcnt <= vcnt - 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        for (int i = 0; i < 60 && !op_ready; i++) step();
        chk("op_ready_wait", {31'd0, op_ready}, 32'd1);
        step();
        op_valid = 1'b0;
    endtask

    task automatic wait_res();
        for (int i = 0; i < 200 && !res_valid; i++) step();
        chk("res_valid_wait", {31'd0, res_valid}, 32'd1);
    endtask

    initial begin
        int s0;

        // reset
        step();
        step();
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_timeout", {31'd0, res_timeout}, 32'd0);
        chk("rst_start", {31'd0, gcd_start}, 32'd0);
        chk("rst_gcd_a", gcd_a, 32'd0);
        chk("rst_gcd_b", gcd_b, 32'd0);
        chk("rst_done", {16'd0, done_count}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_op_ready", {31'd0, op_ready}, 32'd1);

        // 1: (48,18)
        s0 = start_cnt;
        send(48, 18);
        chk("t1_start_n1", {31'd0, gcd_start}, 32'd1);
        chk("t1_op_ready", {31'd0, op_ready}, 32'd0);
        chk("t1_gcd_a", gcd_a, 32'd48);
        chk("t1_gcd_b", gcd_b, 32'd18);
        wait_res();
        chk("t1_data", res_data, 32'd6);
        chk("t1_timeout", {31'd0, res_timeout}, 32'd0);
        chk("t1_starts", 32'(start_cnt - s0), 32'd1);
        chk("t1_op_ready_out", {31'd0, op_ready}, 32'd0);
        step();
        chk("t1_valid_drop", {31'd0, res_valid}, 32'd0);
        chk("t1_done", {16'd0, done_count}, 32'd1);

        // 2: back-to-back (7,13),(100,75)
        send(7, 13);
        wait_res();
        chk("t2a_data", res_data, 32'd1);
        send(100, 75);
        chk("t2b_gcd_a", gcd_a, 32'd100);
        chk("t2b_gcd_b", gcd_b, 32'd75);
        chk("t2b_core_valid_pending", {31'd0, core_valid}, 32'd1);
        chk("t2b_start_held", {31'd0, gcd_start}, 32'd0);
        wait_res();
        chk("t2b_data", res_data, 32'd25);
        step();
        chk("t2_done", {16'd0, done_count}, 32'd3);

        // 3: result back-pressure
        res_ready = 1'b0;
        send(21, 14);
        wait_res();
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("t3_valid", {31'd0, res_valid}, 32'd1);
            chk("t3_data", res_data, 32'd7);
            chk("t3_op_ready", {31'd0, op_ready}, 32'd0);
            step();
        end
        chk("t3_no_start", 32'(start_cnt - s0), 32'd0);
        res_ready = 1'b1;
        step();
        chk("t3_done", {16'd0, done_count}, 32'd4);

        // 4: timeout, TIMEOUT_CYCLES=8
        core_dead = 1'b1;
        send(9, 3);
        chk("t4_start", {31'd0, gcd_start}, 32'd1);
        step();
        for (int i = 1; i < 8; i++) begin
            step();
            chk("t4_early", {31'd0, res_valid}, 32'd0);
        end
        step();
        chk("t4_valid", {31'd0, res_valid}, 32'd1);
        chk("t4_timeout", {31'd0, res_timeout}, 32'd1);
        chk("t4_data", res_data, 32'd0);
        step();
        chk("t4_done", {16'd0, done_count}, 32'd5);
        core_dead = 1'b0;

        // 5a: reset in ISSUE drops start in the same cycle
        send(6, 4);
        chk("t5a_start", {31'd0, gcd_start}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t5a_start_drop", {31'd0, gcd_start}, 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("t5a_done_rst", {16'd0, done_count}, 32'd0);

        // 5b: reset during WAIT_RES
        send(48, 18);
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t5b_op_ready", {31'd0, op_ready}, 32'd1);
        chk("t5b_done", {16'd0, done_count}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("t5b_no_result", {31'd0, res_valid}, 32'd0);
            step();
        end
        send(100, 75);
        wait_res();
        chk("t5b_data", res_data, 32'd25);
        step();
        chk("t5b_done_after", {16'd0, done_count}, 32'd1);

        // 6: zero operand
        s0 = start_cnt;
        send(0, 9);
`ifdef GCD_ZERO_BYPASS_EN
        chk("t6_valid_n1", {31'd0, res_valid}, 32'd1);
        chk("t6_data", res_data, 32'd9);
        chk("t6_no_start", 32'(start_cnt - s0), 32'd0);
        chk("t6_gcd_a_kept", gcd_a, 32'd100);
`else
        chk("t6_gcd_a", gcd_a, 32'd0);
        wait_res();
        chk("t6_data", res_data, 32'd9);
        chk("t6_one_start", 32'(start_cnt - s0), 32'd1);
`endif
        chk("t6_timeout", {31'd0, res_timeout}, 32'd0);
        step();
        chk("t6_done", {16'd0, done_count}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
